// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction-byte prefetch stage for the MCS8 pipeline. It drives the 14-bit
//   address of an asynchronous 16K x 8 program ROM, captures the returned byte
//   together with its address into a small FIFO, and presents the head entry to
//   decode. Redirects from execute (jump/call/return) reload the fetch PC and
//   flush the queue. HALT_I freezes fetching while the queue keeps draining.
//
// Ports
//   CLK_I      in   1    clock, all state changes on the rising edge
//   RST_I      in   1    synchronous reset, active-high
//   ADDR_O     out  14   ROM address (the fetch PC)
//   ROM_DAT_I  in   8    ROM data for ADDR_O, valid in the same cycle
//   DAT_O      out  8    head-of-queue byte (0 when empty)
//   PC_O       out  14   address the head byte was fetched from (0 when empty)
//   VLD_O      out  1    queue not empty
//   RDY_I      in   1    decode accepts the head byte
//   JMP_I      in   1    redirect request pulse
//   JADDR_I    in   14   redirect target
//   HALT_I     in   1    suspend fetching (level)
//   CNT_O      out  $clog2(DEPTH)+1  number of valid entries
//
// Handshake: the head entry transfers to decode on a rising edge where
//   VLD_O=1 and RDY_I=1. VLD_O, DAT_O and PC_O depend on registered state only,
//   never on RDY_I, and hold steady until the transfer edge. A redirect edge
//   discards the head even if RDY_I=1; that is not counted as a transfer.
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int          DEPTH      = 4,
  parameter logic [13:0] RESET_ADDR = 14'h0000
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  output logic [13:0]              ADDR_O,
  input  logic [7:0]               ROM_DAT_I,
  output logic [7:0]               DAT_O,
  output logic [13:0]              PC_O,
  output logic                     VLD_O,
  input  logic                     RDY_I,
  input  logic                     JMP_I,
  input  logic [13:0]              JADDR_I,
  input  logic                     HALT_I,
  output logic [$clog2(DEPTH):0]   CNT_O
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [13:0]   q_addr [DEPTH];
  logic [7:0]    q_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [13:0]   pc;

  logic vld;
  logic pop;
  logic push;

  assign vld  = (cnt != '0);
  assign pop  = vld & RDY_I;
  // A full queue may still accept a byte when the head leaves in the same
  // cycle, which keeps streaming at one byte per cycle with no bubble.
  assign push = ~JMP_I & ~HALT_I & ((cnt != FULL_CNT) | pop);

  // Pointer / count / PC state. Pointers are AW bits wide, so with a
  // power-of-two DEPTH they wrap modulo DEPTH for free.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      pc     <= RESET_ADDR;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (JMP_I) begin
      pc     <= JADDR_I;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        pc     <= pc + 14'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset: entries are only observable through rd_ptr while
  // cnt is non-zero, and every such entry was written first.
  always_ff @(posedge CLK_I) begin
    if (!RST_I && push) begin
      q_addr[wr_ptr] <= pc;
      q_data[wr_ptr] <= ROM_DAT_I;
    end
  end

  assign ADDR_O = pc;
  assign VLD_O  = vld;
  assign CNT_O  = cnt;
  assign DAT_O  = vld ? q_data[rd_ptr] : 8'h00;
  assign PC_O   = vld ? q_addr[rd_ptr] : 14'h0000;

endmodule
